// File: rtl/mul_txn_driver_if.sv
// Port bundle joining mul_txn_driver to its operand source, the multiplier
// under test and the result/statistics sink.
interface mul_txn_driver_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
);
  localparam int OW = 2 * WIDTH + 1;

  logic             op_valid;
  logic             op_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_cin;

  logic [WIDTH-1:0] mul_in1;
  logic [WIDTH-1:0] mul_in2;
  logic             mul_czero;
  logic [OW-1:0]    mul_out;
  logic             mul_cout;

  logic             res_valid;
  logic             res_ready;
  logic [OW-1:0]    res_out;
  logic             res_cout;
  logic [OW-1:0]    res_exact;
  logic [OW-1:0]    res_err;
  logic             res_mismatch;

  logic             stat_clear;
  logic [CNT_W-1:0] stat_count;
  logic [CNT_W-1:0] stat_mism;
  logic [OW-1:0]    stat_max_err;

  // Driver-side view: the block owns the multiplier inputs and all results.
  modport master (
    input  op_valid, op_a, op_b, op_cin,
    input  mul_out, mul_cout,
    input  res_ready, stat_clear,
    output op_ready,
    output mul_in1, mul_in2, mul_czero,
    output res_valid, res_out, res_cout, res_exact, res_err, res_mismatch,
    output stat_count, stat_mism, stat_max_err
  );

  modport slave (
    output op_valid, op_a, op_b, op_cin,
    output mul_out, mul_cout,
    output res_ready, stat_clear,
    input  op_ready,
    input  mul_in1, mul_in2, mul_czero,
    input  res_valid, res_out, res_cout, res_exact, res_err, res_mismatch,
    input  stat_count, stat_mism, stat_max_err
  );
endinterface

// File: rtl/mul_txn_driver.sv
// Drives operand transactions into a combinational (exact or approximate)
// multiplier, captures its result after a settle window and scores its error.
module mul_txn_driver #(
  parameter int WIDTH  = 8,
  parameter int SETTLE = 2,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  mul_txn_driver_if.master bus
);
  localparam int OW = 2 * WIDTH + 1;
  localparam int CW = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             op_ready_q, op_ready_d;
  logic [WIDTH-1:0] in1_q, in1_d;
  logic [WIDTH-1:0] in2_q, in2_d;
  logic             cz_q, cz_d;
  logic             res_valid_q, res_valid_d;
  logic [OW-1:0]    res_out_q, res_out_d;
  logic             res_cout_q, res_cout_d;
  logic [OW-1:0]    res_exact_q, res_exact_d;
  logic [OW-1:0]    res_err_q, res_err_d;
  logic             res_mism_q, res_mism_d;
  logic [CNT_W-1:0] stat_cnt_q, stat_cnt_d;
  logic [CNT_W-1:0] stat_mism_q, stat_mism_d;
  logic [OW-1:0]    stat_max_q, stat_max_d;

  logic [2*WIDTH-1:0] prod;
  logic [OW-1:0]      exact;
  logic [OW-1:0]      err;
  logic               mism;
  logic               capture;

  // Reference product comes from the registered operands, so it is stable
  // for the whole settle window regardless of what the source does.
  assign prod  = (2*WIDTH)'(in1_q) * (2*WIDTH)'(in2_q);
  assign exact = OW'(prod) + OW'(cz_q);
  assign err   = (bus.mul_out >= exact) ? (bus.mul_out - exact) : (exact - bus.mul_out);
  assign mism  = (bus.mul_out != exact);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    in1_d       = in1_q;
    in2_d       = in2_q;
    cz_d        = cz_q;
    res_valid_d = res_valid_q;
    res_out_d   = res_out_q;
    res_cout_d  = res_cout_q;
    res_exact_d = res_exact_q;
    res_err_d   = res_err_q;
    res_mism_d  = res_mism_q;
    capture     = 1'b0;

    case (state_q)
      IDLE: begin
        // op_ready_q gates acceptance so the first cycle after reset is quiet.
        if (bus.op_valid && op_ready_q) begin
          in1_d   = bus.op_a;
          in2_d   = bus.op_b;
          cz_d    = bus.op_cin;
          cnt_d   = CW'(SETTLE - 1);
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        if (cnt_q == '0) begin
          capture     = 1'b1;
          res_out_d   = bus.mul_out;
          res_cout_d  = bus.mul_cout;
          res_exact_d = exact;
          res_err_d   = err;
          res_mism_d  = mism;
          res_valid_d = 1'b1;
          state_d     = HOLD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      HOLD: begin
        if (bus.res_ready) begin
          res_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    op_ready_d = (state_d == IDLE);
  end

  // Statistics: a clear always wins over a same-edge capture.
  always_comb begin
    stat_cnt_d  = stat_cnt_q;
    stat_mism_d = stat_mism_q;
    stat_max_d  = stat_max_q;
    if (bus.stat_clear) begin
      stat_cnt_d  = '0;
      stat_mism_d = '0;
      stat_max_d  = '0;
    end else if (capture) begin
      if (stat_cnt_q != '1) begin
        stat_cnt_d = stat_cnt_q + CNT_W'(1);
      end
      if (mism && (stat_mism_q != '1)) begin
        stat_mism_d = stat_mism_q + CNT_W'(1);
      end
      if (err > stat_max_q) begin
        stat_max_d = err;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      op_ready_q  <= 1'b0;
      in1_q       <= '0;
      in2_q       <= '0;
      cz_q        <= 1'b0;
      res_valid_q <= 1'b0;
      res_out_q   <= '0;
      res_cout_q  <= 1'b0;
      res_exact_q <= '0;
      res_err_q   <= '0;
      res_mism_q  <= 1'b0;
      stat_cnt_q  <= '0;
      stat_mism_q <= '0;
      stat_max_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_ready_q  <= op_ready_d;
      in1_q       <= in1_d;
      in2_q       <= in2_d;
      cz_q        <= cz_d;
      res_valid_q <= res_valid_d;
      res_out_q   <= res_out_d;
      res_cout_q  <= res_cout_d;
      res_exact_q <= res_exact_d;
      res_err_q   <= res_err_d;
      res_mism_q  <= res_mism_d;
      stat_cnt_q  <= stat_cnt_d;
      stat_mism_q <= stat_mism_d;
      stat_max_q  <= stat_max_d;
    end
  end

  assign bus.op_ready     = op_ready_q;
  assign bus.mul_in1      = in1_q;
  assign bus.mul_in2      = in2_q;
  assign bus.mul_czero    = cz_q;
  assign bus.res_valid    = res_valid_q;
  assign bus.res_out      = res_out_q;
  assign bus.res_cout     = res_cout_q;
  assign bus.res_exact    = res_exact_q;
  assign bus.res_err      = res_err_q;
  assign bus.res_mismatch = res_mism_q;
  assign bus.stat_count   = stat_cnt_q;
  assign bus.stat_mism    = stat_mism_q;
  assign bus.stat_max_err = stat_max_q;
endmodule
